pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
Front-end flow controller for the 5-stage RV32 pipeline. It sequences the PC register and the IF/ID and ID/EX pipeline registers.
- Arbitrates between next-PC sources: sequential, EX-stage branch redirect and ID-stage jump.
- Merges stall sources: instruction-memory busy, data-memory busy and load-use hazard.
- Generates PC hold/load and pipeline stall/flush controls.
- Buffers a redirect that arrives while the fetch side is busy, so no redirect is ever lost.

Parameters:
- XLEN, 32, width of PC and target buses.
- RESET_HOLD_CYCLES, 2, cycles the pipeline stays frozen and flushed after RESET deasserts; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- IMEM_BUSY  in  1  instruction memory cannot accept a fetch this cycle.
- DMEM_BUSY  in  1  data memory stalling MEM stage; freezes whole pipeline.
- LOAD_USE  in  1  ID instruction depends on load currently in EX.
- BR_TAKEN  in  1  EX resolved taken branch / JALR.
- BR_TARGET  in  XLEN  absolute target for BR_TAKEN.
- JMP_VALID  in  1  ID decoded JAL.
- JMP_TARGET  in  XLEN  absolute target for JMP_VALID.
- PC_STALL  out  1  hold PC; drives PC unit BUSY_WAIT.
- PC_LOAD  out  1  load PC_NEXT into PC at next edge.
- PC_NEXT  out  XLEN  redirect target.
- STALL_IFID  out  1  hold IF/ID register.
- FLUSH_IFID  out  1  bubble IF/ID.
- STALL_IDEX  out  1  hold ID/EX register.
- FLUSH_IDEX  out  1  bubble ID/EX.
- CTRL_STATE  out  2  current FSM state, debug.

Behaviour:
- FSM states:
  - RST_HOLD=0
  - RUN=1
  - REDIR_WAIT=2
  - Encoding 3 unused; it must recover to RUN.
- Signal definitions:
  - busy = IMEM_BUSY | DMEM_BUSY.
  - src_sel picks BR_TAKEN over JMP_VALID.
- RESET asserted, at any time and in any state:
  - State goes to RST_HOLD immediately.
  - hold_cnt = RESET_HOLD_CYCLES.
  - pend_valid = 0, pend_target = 0.
  - Outputs: PC_STALL=1, FLUSH_IFID=1, FLUSH_IDEX=1, PC_LOAD=0, PC_NEXT=0, STALL_IFID=0, STALL_IDEX=0.
  - A RESET mid-redirect discards the pending target.
- RST_HOLD:
  - Outputs as in reset; hold_cnt decrements each edge.
  - At hold_cnt==1 the next state is RUN.
  - All inputs are ignored.
- RUN: outputs are combinational, with priority in this order:
  - (a) BR_TAKEN & !busy:
    - PC_LOAD=1, PC_NEXT=BR_TARGET, FLUSH_IFID=1, FLUSH_IDEX=1, PC_STALL=0.
    - LOAD_USE and JMP_VALID are ignored (wrong path).
  - (b) BR_TAKEN & busy:
    - Latch pend_target=BR_TARGET, pend_valid=1, and go to REDIR_WAIT.
    - This cycle: PC_STALL=1, FLUSH_IFID=1.
    - FLUSH_IDEX=!DMEM_BUSY; with DMEM_BUSY set, STALL_IDEX=1 instead.
  - (c) DMEM_BUSY:
    - PC_STALL=1, STALL_IFID=1, STALL_IDEX=1, no flush.
    - JMP_VALID and LOAD_USE are held, not acted on.
  - (d) LOAD_USE:
    - PC_STALL=1, STALL_IFID=1, FLUSH_IDEX=1 (exactly one bubble per asserted cycle).
    - JMP_VALID is deferred because the jump stays in ID.
  - (e) JMP_VALID & !IMEM_BUSY:
    - PC_LOAD=1, PC_NEXT=JMP_TARGET, FLUSH_IFID=1.
  - (f) JMP_VALID & IMEM_BUSY:
    - Latch pend_target=JMP_TARGET, go to REDIR_WAIT, FLUSH_IFID=1, PC_STALL=1.
  - (g) IMEM_BUSY: PC_STALL=1, STALL_IFID=0, FLUSH_IFID=1 (no valid fetch).
  - (h) Otherwise all outputs are 0 and the PC advances by 4.
- REDIR_WAIT:
  - PC_STALL=1 and FLUSH_IFID=1 while busy.
  - FLUSH_IDEX=1 unless DMEM_BUSY; with DMEM_BUSY set, STALL_IDEX=1.
  - BR_TAKEN, JMP_VALID and LOAD_USE are ignored: the pending redirect is the oldest and is never overwritten.
  - On the first cycle with !busy: PC_LOAD=1, PC_NEXT=pend_target, FLUSH_IFID=1.
  - On that edge pend_valid is cleared and the state goes to RUN.
- Invariants:
  - PC_LOAD and PC_STALL are never both 1.
  - STALL_x and FLUSH_x for the same register are never both 1.
  - Targets are passed unmodified, with no alignment check.

Optional Feature:
PC_FLOW_PERF_EN:
- Defined: adds outputs STALL_CNT[31:0], FLUSH_CNT[31:0] and REDIR_CNT[31:0].
  - STALL_CNT counts cycles in RUN or REDIR_WAIT with PC_STALL=1.
  - FLUSH_CNT counts cycles with FLUSH_IFID=1 outside RST_HOLD.
  - REDIR_CNT counts PC_LOAD pulses.
  - All three wrap at 2^32 and clear on RESET.
- Undefined: these ports and registers are absent.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State enum (RST_HOLD, RUN, REDIR_WAIT).
  - XLEN default.
  - Bubble encoding constant, reused by hazard unit and pipeline registers.
- One natural sub-module, pc_redirect_buf: holds pend_valid/pend_target with capture and release handshake.
- Counters stay inline.

Test Plan:
1. RESET pulse with RESET_HOLD_CYCLES=2 -> flushes=1 and PC_STALL=1 for 2 cycles after deassert, then RUN with all outputs 0.
2. BR_TAKEN=1, BR_TARGET=0x100 with both busy=0 -> same cycle PC_LOAD=1, PC_NEXT=0x100, FLUSH_IFID=FLUSH_IDEX=1; next cycle idle.
3. BR_TAKEN with target 0x200 while IMEM_BUSY=1 for 3 cycles, plus JMP_VALID target 0x300 in cycle 2 -> REDIR_WAIT for 3 cycles, then one PC_LOAD with PC_NEXT=0x200; 0x300 is never loaded.
4. LOAD_USE=1 for 1 cycle with JMP_VALID=1 -> cycle 1: PC_STALL=1, STALL_IFID=1, FLUSH_IDEX=1; cycle 2: PC_LOAD=1, PC_NEXT=JMP_TARGET.
5. DMEM_BUSY=1 for 4 cycles with BR_TAKEN=1 (target 0x40) -> STALL_IDEX=1 and FLUSH_IDEX=0 throughout; PC_LOAD with 0x40 in the first cycle after DMEM_BUSY drops.
6. RESET asserted while in REDIR_WAIT -> state RST_HOLD immediately; after hold, no PC_LOAD of the stale target.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared front-end pipeline control definitions: FSM states, default bus width
// and the bubble instruction that hazard logic and pipeline registers insert.
package pipe_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int HOLD_CNT_W   = 4;

  // addi x0, x0, 0 -- the canonical RV32 NOP used as a pipeline bubble
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RST_HOLD   = 2'd0,
    RUN        = 2'd1,
    REDIR_WAIT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// Handshake/status bundle between the pipeline front end and pc_flow_ctrl.
// The controller takes the slave view; the pipeline side takes the master view.
interface pc_flow_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            IMEM_BUSY;
  logic            DMEM_BUSY;
  logic            LOAD_USE;
  logic            BR_TAKEN;
  logic [XLEN-1:0] BR_TARGET;
  logic            JMP_VALID;
  logic [XLEN-1:0] JMP_TARGET;

  logic            PC_STALL;
  logic            PC_LOAD;
  logic [XLEN-1:0] PC_NEXT;
  logic            STALL_IFID;
  logic            FLUSH_IFID;
  logic            STALL_IDEX;
  logic            FLUSH_IDEX;
  logic [1:0]      CTRL_STATE;

  modport master (
    output IMEM_BUSY, DMEM_BUSY, LOAD_USE, BR_TAKEN, BR_TARGET, JMP_VALID, JMP_TARGET,
    input  PC_STALL, PC_LOAD, PC_NEXT, STALL_IFID, FLUSH_IFID, STALL_IDEX, FLUSH_IDEX,
           CTRL_STATE
  );

  modport slave (
    input  IMEM_BUSY, DMEM_BUSY, LOAD_USE, BR_TAKEN, BR_TARGET, JMP_VALID, JMP_TARGET,
    output PC_STALL, PC_LOAD, PC_NEXT, STALL_IFID, FLUSH_IFID, STALL_IDEX, FLUSH_IDEX,
           CTRL_STATE
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer for a redirect target that could not be applied because
// the fetch side was busy; the first capture wins until it is released.
module pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            capture,
  input  logic [XLEN-1:0] capture_target,
  input  logic            release_req,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  // An occupied entry is never overwritten: the oldest redirect must be honoured.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (capture && !pend_valid) begin
      pend_valid  <= 1'b1;
      pend_target <= capture_target;
    end else if (release_req) begin
      pend_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Front-end flow controller: PC source arbitration, stall merging and IF/ID, ID/EX
// stall/flush generation. Define PC_FLOW_PERF_EN to add stall/flush/redirect counters.
module pc_flow_ctrl import pipe_ctrl_pkg::*; #(
  parameter int XLEN              = XLEN_DEFAULT,
  parameter int RESET_HOLD_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  pc_flow_ctrl_if.slave      bus
`ifdef PC_FLOW_PERF_EN
  ,
  output logic [31:0]        STALL_CNT,
  output logic [31:0]        FLUSH_CNT,
  output logic [31:0]        REDIR_CNT
`endif
);

  ctrl_state_e           state;
  ctrl_state_e           state_next;
  logic [HOLD_CNT_W-1:0] hold_cnt;

  logic            busy;
  logic            capture;
  logic            release_req;
  logic [XLEN-1:0] capture_target;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;

  logic            pc_stall;
  logic            pc_load;
  logic [XLEN-1:0] pc_next;
  logic            stall_ifid;
  logic            flush_ifid;
  logic            stall_idex;
  logic            flush_idex;

  assign busy           = bus.IMEM_BUSY | bus.DMEM_BUSY;
  assign capture_target = bus.BR_TAKEN ? bus.BR_TARGET : bus.JMP_TARGET;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= RST_HOLD;
      hold_cnt <= 4'(RESET_HOLD_CYCLES);
    end else begin
      state <= state_next;
      if (state == RST_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_comb begin
    state_next = RUN;
    case (state)
      RST_HOLD:   state_next = (hold_cnt <= 4'd1) ? RUN : RST_HOLD;
      RUN:        state_next = capture ? REDIR_WAIT : RUN;
      REDIR_WAIT: state_next = busy ? REDIR_WAIT : RUN;
      default:    state_next = RUN;
    endcase
  end

  // RUN resolves sources in age order: EX branch, memory stall, load-use, ID jump, fetch stall.
  always_comb begin
    pc_stall    = 1'b0;
    pc_load     = 1'b0;
    pc_next     = '0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_idex  = 1'b0;
    capture     = 1'b0;
    release_req = 1'b0;
    case (state)
      RST_HOLD: begin
        pc_stall   = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      RUN: begin
        if (bus.BR_TAKEN && !busy) begin
          pc_load    = 1'b1;
          pc_next    = bus.BR_TARGET;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (bus.BR_TAKEN) begin
          capture    = 1'b1;
          pc_stall   = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = !bus.DMEM_BUSY;
          stall_idex = bus.DMEM_BUSY;
        end else if (bus.DMEM_BUSY) begin
          pc_stall   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
        end else if (bus.LOAD_USE) begin
          pc_stall   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (bus.JMP_VALID && !bus.IMEM_BUSY) begin
          pc_load    = 1'b1;
          pc_next    = bus.JMP_TARGET;
          flush_ifid = 1'b1;
        end else if (bus.JMP_VALID) begin
          capture    = 1'b1;
          pc_stall   = 1'b1;
          flush_ifid = 1'b1;
        end else if (bus.IMEM_BUSY) begin
          pc_stall   = 1'b1;
          flush_ifid = 1'b1;
        end
      end
      REDIR_WAIT: begin
        flush_ifid = 1'b1;
        flush_idex = !bus.DMEM_BUSY;
        stall_idex = bus.DMEM_BUSY;
        if (busy) begin
          pc_stall = 1'b1;
        end else if (pend_valid) begin
          pc_load     = 1'b1;
          pc_next     = pend_target;
          release_req = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .CLK            (CLK),
    .RESET          (RESET),
    .capture        (capture),
    .capture_target (capture_target),
    .release_req    (release_req),
    .pend_valid     (pend_valid),
    .pend_target    (pend_target)
  );

  assign bus.PC_STALL   = pc_stall;
  assign bus.PC_LOAD    = pc_load;
  assign bus.PC_NEXT    = pc_next;
  assign bus.STALL_IFID = stall_ifid;
  assign bus.FLUSH_IFID = flush_ifid;
  assign bus.STALL_IDEX = stall_idex;
  assign bus.FLUSH_IDEX = flush_idex;
  assign bus.CTRL_STATE = state;

`ifdef PC_FLOW_PERF_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
      REDIR_CNT <= '0;
    end else begin
      if ((state == RUN || state == REDIR_WAIT) && pc_stall)
        STALL_CNT <= STALL_CNT + 32'd1;
      if (state != RST_HOLD && flush_ifid)
        FLUSH_CNT <= FLUSH_CNT + 32'd1;
      if (pc_load)
        REDIR_CNT <= REDIR_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_pc_flow_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int HOLD = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  pc_flow_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef PC_FLOW_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, redir_cnt;
`endif

  pc_flow_ctrl #(.XLEN(XLEN), .RESET_HOLD_CYCLES(HOLD)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef PC_FLOW_PERF_EN
    ,
    .STALL_CNT (stall_cnt),
    .FLUSH_CNT (flush_cnt),
    .REDIR_CNT (redir_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, imem, dmem, lu, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jmpt;
  } stim_t;

  typedef struct {
    logic        pc_stall, pc_load;
    logic [31:0] pc_next;
    logic        stall_ifid, flush_ifid, stall_idex, flush_idex;
    logic [1:0]  state;
  } exp_t;

  int total  = 0;
  int passed = 0;

  // Reference model: remaining frozen cycles plus a queue of outstanding redirects
  int          hold_left = HOLD;
  logic [31:0] pend_q[$];
  logic [31:0] m_stall_cnt = 0, m_flush_cnt = 0, m_redir_cnt = 0;

  function automatic stim_t mk(input logic rst, input logic imem, input logic dmem,
                               input logic lu, input logic br, input logic [31:0] brt,
                               input logic jmp, input logic [31:0] jmpt);
    stim_t s;
    s.rst = rst; s.imem = imem; s.dmem = dmem; s.lu = lu;
    s.br = br; s.brt = brt; s.jmp = jmp; s.jmpt = jmpt;
    return s;
  endfunction

  function automatic exp_t modelEval(input stim_t s);
    exp_t e;
    logic busy;
    busy = s.imem | s.dmem;
    e.pc_stall = 0; e.pc_load = 0; e.pc_next = 0;
    e.stall_ifid = 0; e.flush_ifid = 0; e.stall_idex = 0; e.flush_idex = 0;
    if (s.rst || hold_left > 0) begin
      e.state = 2'd0;
      e.pc_stall = 1; e.flush_ifid = 1; e.flush_idex = 1;
    end else if (pend_q.size() != 0) begin
      e.state = 2'd2;
      e.flush_ifid = 1; e.flush_idex = !s.dmem; e.stall_idex = s.dmem;
      if (busy) e.pc_stall = 1;
      else begin e.pc_load = 1; e.pc_next = pend_q[0]; end
    end else begin
      e.state = 2'd1;
      if (s.br && !busy) begin
        e.pc_load = 1; e.pc_next = s.brt; e.flush_ifid = 1; e.flush_idex = 1;
      end else if (s.br) begin
        e.pc_stall = 1; e.flush_ifid = 1; e.flush_idex = !s.dmem; e.stall_idex = s.dmem;
      end else if (s.dmem) begin
        e.pc_stall = 1; e.stall_ifid = 1; e.stall_idex = 1;
      end else if (s.lu) begin
        e.pc_stall = 1; e.stall_ifid = 1; e.flush_idex = 1;
      end else if (s.jmp && !s.imem) begin
        e.pc_load = 1; e.pc_next = s.jmpt; e.flush_ifid = 1;
      end else if (s.jmp || s.imem) begin
        e.pc_stall = 1; e.flush_ifid = 1;
      end
    end
    return e;
  endfunction

  task automatic modelAdvance(input stim_t s, input exp_t e);
    logic busy;
    busy = s.imem | s.dmem;
    if (s.rst) begin
      hold_left = HOLD;
      pend_q.delete();
      m_stall_cnt = 0; m_flush_cnt = 0; m_redir_cnt = 0;
    end else begin
      if (e.state != 2'd0 && e.pc_stall)   m_stall_cnt++;
      if (e.state != 2'd0 && e.flush_ifid) m_flush_cnt++;
      if (e.pc_load)                       m_redir_cnt++;
      if (hold_left > 0) hold_left--;
      else if (pend_q.size() != 0) begin
        if (!busy) void'(pend_q.pop_front());
      end else if (s.br && busy) pend_q.push_back(s.brt);
      else if (!s.br && !s.dmem && !s.lu && s.jmp && s.imem) pend_q.push_back(s.jmpt);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("pc_stall",   32'(bus.PC_STALL),   32'(e.pc_stall));
    checkVal("pc_load",    32'(bus.PC_LOAD),    32'(e.pc_load));
    checkVal("pc_next",    bus.PC_NEXT,         e.pc_next);
    checkVal("stall_ifid", 32'(bus.STALL_IFID), 32'(e.stall_ifid));
    checkVal("flush_ifid", 32'(bus.FLUSH_IFID), 32'(e.flush_ifid));
    checkVal("stall_idex", 32'(bus.STALL_IDEX), 32'(e.stall_idex));
    checkVal("flush_idex", 32'(bus.FLUSH_IDEX), 32'(e.flush_idex));
    checkVal("ctrl_state", 32'(bus.CTRL_STATE), 32'(e.state));
    checkVal("inv_load_and_stall", 32'(bus.PC_LOAD & bus.PC_STALL), 32'd0);
    checkVal("inv_ifid_stall_flush", 32'(bus.STALL_IFID & bus.FLUSH_IFID), 32'd0);
    checkVal("inv_idex_stall_flush", 32'(bus.STALL_IDEX & bus.FLUSH_IDEX), 32'd0);
`ifdef PC_FLOW_PERF_EN
    checkVal("stall_cnt", stall_cnt, m_stall_cnt);
    checkVal("flush_cnt", flush_cnt, m_flush_cnt);
    checkVal("redir_cnt", redir_cnt, m_redir_cnt);
`endif
  endtask

  // Drive just after the rising edge, compare at the falling edge, then step the model
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET          = s.rst;
    bus.IMEM_BUSY  = s.imem;
    bus.DMEM_BUSY  = s.dmem;
    bus.LOAD_USE   = s.lu;
    bus.BR_TAKEN   = s.br;
    bus.BR_TARGET  = s.brt;
    bus.JMP_VALID  = s.jmp;
    bus.JMP_TARGET = s.jmpt;
    @(negedge CLK);
    e = modelEval(s);
    checkOutput(e);
    modelAdvance(s, e);
  endtask

  initial begin
    stim_t idle;
    stim_t s;
    idle = mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    bus.IMEM_BUSY = 0; bus.DMEM_BUSY = 0; bus.LOAD_USE = 0; bus.BR_TAKEN = 0;
    bus.BR_TARGET = 0; bus.JMP_VALID = 0; bus.JMP_TARGET = 0;

    // Reset pulse, two frozen cycles, then idle RUN
    applyStimulus(mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0));
    checkVal("t1_reset_state", 32'(bus.CTRL_STATE), 32'd0);
    applyStimulus(mk(1, 1, 1, 1, 1, 32'h44, 1, 32'h88));
    checkVal("t1_reset_pc_load", 32'(bus.PC_LOAD), 32'd0);
    for (int i = 0; i < HOLD; i++) begin
      applyStimulus(idle);
      checkVal("t1_hold_pc_stall", 32'(bus.PC_STALL), 32'd1);
      checkVal("t1_hold_flush_idex", 32'(bus.FLUSH_IDEX), 32'd1);
    end
    applyStimulus(idle);
    checkVal("t1_run_state", 32'(bus.CTRL_STATE), 32'd1);
    checkVal("t1_run_pc_stall", 32'(bus.PC_STALL), 32'd0);
    checkVal("t1_run_flush_ifid", 32'(bus.FLUSH_IFID), 32'd0);

    // Unbusy branch redirect
    applyStimulus(mk(0, 0, 0, 0, 1, 32'h100, 0, 32'h0));
    checkVal("t2_pc_load", 32'(bus.PC_LOAD), 32'd1);
    checkVal("t2_pc_next", bus.PC_NEXT, 32'h100);
    checkVal("t2_flush_idex", 32'(bus.FLUSH_IDEX), 32'd1);
    applyStimulus(idle);
    checkVal("t2_idle_pc_load", 32'(bus.PC_LOAD), 32'd0);

    // Branch while fetch busy; a later jump must not overwrite it
    applyStimulus(mk(0, 1, 0, 0, 1, 32'h200, 0, 32'h0));
    applyStimulus(mk(0, 1, 0, 0, 0, 32'h0, 1, 32'h300));
    checkVal("t3_wait_state", 32'(bus.CTRL_STATE), 32'd2);
    applyStimulus(mk(0, 1, 0, 0, 0, 32'h0, 0, 32'h0));
    applyStimulus(idle);
    checkVal("t3_pc_load", 32'(bus.PC_LOAD), 32'd1);
    checkVal("t3_pc_next", bus.PC_NEXT, 32'h200);
    applyStimulus(idle);
    checkVal("t3_no_second_load", 32'(bus.PC_LOAD), 32'd0);

    // Load-use defers the jump by one cycle
    applyStimulus(mk(0, 0, 0, 1, 0, 32'h0, 1, 32'h480));
    checkVal("t4_stall_ifid", 32'(bus.STALL_IFID), 32'd1);
    checkVal("t4_flush_idex", 32'(bus.FLUSH_IDEX), 32'd1);
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h480));
    checkVal("t4_pc_next", bus.PC_NEXT, 32'h480);

    // Data-memory stall holds ID/EX until the branch can be applied
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(0, 0, 1, 0, 1, 32'h40, 0, 32'h0));
      checkVal("t5_stall_idex", 32'(bus.STALL_IDEX), 32'd1);
      checkVal("t5_flush_idex", 32'(bus.FLUSH_IDEX), 32'd0);
    end
    applyStimulus(idle);
    checkVal("t5_pc_next", bus.PC_NEXT, 32'h40);

    // Reset during REDIR_WAIT discards the pending target
    applyStimulus(mk(0, 1, 0, 0, 1, 32'h555, 0, 32'h0));
    applyStimulus(mk(0, 1, 0, 0, 0, 32'h0, 0, 32'h0));
    checkVal("t6_wait_state", 32'(bus.CTRL_STATE), 32'd2);
    applyStimulus(mk(1, 1, 0, 0, 0, 32'h0, 0, 32'h0));
    checkVal("t6_reset_state", 32'(bus.CTRL_STATE), 32'd0);
    for (int i = 0; i < HOLD + 2; i++) begin
      applyStimulus(idle);
      checkVal("t6_no_stale_load", 32'(bus.PC_LOAD), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 249) == 0);
      s.imem = ($urandom_range(0, 3) == 0);
      s.dmem = ($urandom_range(0, 5) == 0);
      s.lu   = ($urandom_range(0, 5) == 0);
      s.br   = ($urandom_range(0, 7) == 0);
      s.brt  = $urandom();
      s.jmp  = ($urandom_range(0, 5) == 0);
      s.jmpt = $urandom();
      applyStimulus(s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
